// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared instruction/data memory port between boot loader, fetch and data ports.
// Each access runs IDLE -> ACCESS -> DONE; ld owns the port during boot, otherwise if/dm round-robin.
module mem_port_arbiter #(
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned DATA_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              boot,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [31:0]       ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_done,
  output logic              ld_err,
  output logic [DATA_W-1:0] ld_rdata,
  input  logic              if_req,
  input  logic              if_we,
  input  logic [31:0]       if_addr,
  input  logic [DATA_W-1:0] if_wdata,
  output logic              if_done,
  output logic              if_err,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [31:0]       dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_done,
  output logic              dm_err,
  output logic [DATA_W-1:0] dm_rdata,
  output logic [31:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;
  typedef enum logic [1:0] {ID_LD, ID_IF, ID_DM} id_t;

  state_t            state, state_nx;
  id_t               grant_id, id_q;
  logic              grant_vld;
  logic              sel_we, we_q;
  logic [31:0]       sel_addr, addr_q;
  logic [DATA_W-1:0] sel_wdata, wdata_q;
  logic              rr_last_dm;
  logic              ok;

  // Word aligned and inside the 4<<ADDR_BITS byte window
  assign ok = (addr_q[1:0] == 2'b00) && (addr_q[31:ADDR_BITS+2] == '0);

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Selection only happens in IDLE; a tie goes to whichever of if/dm was not served last
  always_comb begin
    state_nx  = state;
    grant_vld = 1'b0;
    grant_id  = ID_LD;
    unique case (state)
      S_IDLE: begin
        if (boot) begin
          if (ld_req) begin
            grant_vld = 1'b1;
            grant_id  = ID_LD;
          end
        end else if (if_req && dm_req) begin
          grant_vld = 1'b1;
          grant_id  = rr_last_dm ? ID_IF : ID_DM;
        end else if (if_req) begin
          grant_vld = 1'b1;
          grant_id  = ID_IF;
        end else if (dm_req) begin
          grant_vld = 1'b1;
          grant_id  = ID_DM;
        end
        if (grant_vld) state_nx = S_ACCESS;
      end
      S_ACCESS: state_nx = S_DONE;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    sel_we    = ld_we;
    sel_addr  = ld_addr;
    sel_wdata = ld_wdata;
    case (grant_id)
      ID_IF: begin
        sel_we    = if_we;
        sel_addr  = if_addr;
        sel_wdata = if_wdata;
      end
      ID_DM: begin
        sel_we    = dm_we;
        sel_addr  = dm_addr;
        sel_wdata = dm_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_q       <= ID_LD;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rr_last_dm <= 1'b1;
    end else begin
      if (grant_vld) begin
        id_q    <= grant_id;
        we_q    <= sel_we;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
      end
      if (state == S_DONE && id_q != ID_LD) rr_last_dm <= (id_q == ID_DM);
    end
  end

  // Read data lands in the owner's register at the edge closing ACCESS
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_rdata <= '0;
      if_rdata <= '0;
      dm_rdata <= '0;
    end else if (state == S_ACCESS && !we_q && ok) begin
      case (id_q)
        ID_LD:   ld_rdata <= mem_rdata;
        ID_IF:   if_rdata <= mem_rdata;
        ID_DM:   dm_rdata <= mem_rdata;
        default: ;
      endcase
    end
  end

  // Memory strobes and completion flags depend only on state and latched registers
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    ld_done   = 1'b0;
    ld_err    = 1'b0;
    if_done   = 1'b0;
    if_err    = 1'b0;
    dm_done   = 1'b0;
    dm_err    = 1'b0;
    if (state == S_ACCESS) begin
      mem_read  = ~we_q & ok;
      mem_write = we_q & ok;
    end
    if (state == S_DONE) begin
      case (id_q)
        ID_LD: begin
          ld_done = 1'b1;
          ld_err  = ~ok;
        end
        ID_IF: begin
          if_done = 1'b1;
          if_err  = ~ok;
        end
        ID_DM: begin
          dm_done = 1'b1;
          dm_err  = ~ok;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_mem_port_arbiter;
  localparam int unsigned ADDR_BITS = 8;
  localparam int unsigned DATA_W    = 32;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic boot  = 1'b1;

  logic              ld_req = 1'b0, ld_we = 1'b0;
  logic [31:0]       ld_addr = '0;
  logic [DATA_W-1:0] ld_wdata = '0;
  logic              if_req = 1'b0, if_we = 1'b0;
  logic [31:0]       if_addr = '0;
  logic [DATA_W-1:0] if_wdata = '0;
  logic              dm_req = 1'b0, dm_we = 1'b0;
  logic [31:0]       dm_addr = '0;
  logic [DATA_W-1:0] dm_wdata = '0;
  logic              ld_done, ld_err, if_done, if_err, dm_done, dm_err;
  logic [DATA_W-1:0] ld_rdata, if_rdata, dm_rdata;
  logic [31:0]       mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              mem_read, mem_write;

  mem_port_arbiter #(.ADDR_BITS(ADDR_BITS), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .boot(boot),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_done(ld_done), .ld_err(ld_err), .ld_rdata(ld_rdata),
    .if_req(if_req), .if_we(if_we), .if_addr(if_addr), .if_wdata(if_wdata),
    .if_done(if_done), .if_err(if_err), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_done(dm_done), .dm_err(dm_err), .dm_rdata(dm_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory seen by the DUT: combinational read, write at the clock edge
  logic [31:0] tb_mem [256] = '{default: '0};
  assign mem_rdata = tb_mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_write) tb_mem[mem_addr[9:2]] <= mem_wdata;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int mw_count = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (mem_write === 1'b1) mw_count <= mw_count + 1;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (ports: 0=ld 1=if 2=dm) ----------------
  bit          m_active = 1'b0;
  int          m_g = 0;
  int          m_id = 0;
  bit          m_we = 1'b0, m_ok = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0;
  int          m_last = 2;
  logic [31:0] exp_rdata [3] = '{default: '0};
  logic [31:0] model_mem [256] = '{default: '0};

  function automatic int pick();
    if (boot) return ld_req ? 0 : -1;
    if (if_req && dm_req) return (m_last == 1) ? 2 : 1;
    if (if_req) return 1;
    if (dm_req) return 2;
    return -1;
  endfunction

  function automatic logic port_we(input int p);
    case (p)
      0:       return ld_we;
      1:       return if_we;
      default: return dm_we;
    endcase
  endfunction

  function automatic logic [31:0] port_addr(input int p);
    case (p)
      0:       return ld_addr;
      1:       return if_addr;
      default: return dm_addr;
    endcase
  endfunction

  function automatic logic [31:0] port_wdata(input int p);
    case (p)
      0:       return ld_wdata;
      1:       return if_wdata;
      default: return dm_wdata;
    endcase
  endfunction

  function automatic bit addr_ok(input logic [31:0] a);
    return (a % 4 == 0) && (a < 32'(4 << ADDR_BITS));
  endfunction

  // A grant seen at an edge makes the next cycle the access and the one after it the completion
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active  <= 1'b0;
      m_last    <= 2;
      exp_rdata <= '{default: '0};
    end else if (m_active) begin
      if (cyc == m_g && m_ok) begin
        if (m_we) model_mem[8'(m_addr >> 2)] <= m_wdata;
        else      exp_rdata[m_id] <= model_mem[8'(m_addr >> 2)];
      end
      if (cyc == m_g + 1) m_active <= 1'b0;
    end else if (pick() >= 0) begin
      m_active <= 1'b1;
      m_g      <= cyc + 1;
      m_id     <= pick();
      m_we     <= port_we(pick());
      m_addr   <= port_addr(pick());
      m_wdata  <= port_wdata(pick());
      m_ok     <= addr_ok(port_addr(pick()));
      if (pick() != 0) m_last <= pick();
    end
  end

  logic exp_acc, exp_dn;
  assign exp_acc = m_active && (cyc == m_g);
  assign exp_dn  = m_active && (cyc == m_g + 1);

  function automatic logic err_of(input int p);
    case (p)
      0:       return ld_err;
      1:       return if_err;
      default: return dm_err;
    endcase
  endfunction

  function automatic logic done_of(input int p);
    case (p)
      0:       return ld_done;
      1:       return if_done;
      default: return dm_done;
    endcase
  endfunction

  always @(negedge clk) begin
    chk1("mem_read", mem_read, exp_acc && !m_we && m_ok);
    chk1("mem_write", mem_write, exp_acc && m_we && m_ok);
    if (exp_acc) begin
      chk32("mem_addr", mem_addr, m_addr);
      if (m_we && m_ok) chk32("mem_wdata", mem_wdata, m_wdata);
    end
    chk1("ld_done", ld_done, exp_dn && m_id == 0);
    chk1("if_done", if_done, exp_dn && m_id == 1);
    chk1("dm_done", dm_done, exp_dn && m_id == 2);
    if (exp_dn) chk1("err", err_of(m_id), !m_ok);
    chk32("ld_rdata", ld_rdata, exp_rdata[0]);
    chk32("if_rdata", if_rdata, exp_rdata[1]);
    chk32("dm_rdata", dm_rdata, exp_rdata[2]);
  end

  // ---------------- stimulus ----------------
  task automatic set_port(input int p, input logic req, input logic we,
                          input logic [31:0] a, input logic [31:0] d);
    case (p)
      0: begin ld_req = req; ld_we = we; ld_addr = a; ld_wdata = d; end
      1: begin if_req = req; if_we = we; if_addr = a; if_wdata = d; end
      default: begin dm_req = req; dm_we = we; dm_addr = a; dm_wdata = d; end
    endcase
  endtask

  // Uncontended access: done must arrive two cycles after the request; returns in the following IDLE cycle
  task automatic access(input int p, input logic we, input logic [31:0] a,
                        input logic [31:0] d, output logic err);
    int start;
    int lat;
    start = cyc;
    lat   = -1;
    err   = 1'b0;
    set_port(p, 1'b1, we, a, d);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done_of(p)) begin
        lat = cyc - start;
        err = err_of(p);
        break;
      end
    end
    set_port(p, 1'b0, 1'b0, '0, '0);
    chk32("latency", 32'(lat), 32'd2);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    set_port(0, 1'b0, 1'b0, '0, '0);
    set_port(1, 1'b0, 1'b0, '0, '0);
    set_port(2, 1'b0, 1'b0, '0, '0);
    reset = 1'b1;
    @(negedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  initial begin
    logic e;
    int   nd, nm, mw0, start, lat;
    int   seq[$];
    int   tms[$];

    // Reset state
    repeat (2) @(negedge clk);
    chk1("rst_mem_read", mem_read, 1'b0);
    chk1("rst_mem_write", mem_write, 1'b0);
    chk1("rst_ld_done", ld_done, 1'b0);
    chk32("rst_mem_addr", mem_addr, 32'h0);
    chk32("rst_dm_rdata", dm_rdata, 32'h0);
    #1 reset = 1'b0;

    // 1: boot loader write then read back
    access(0, 1'b1, 32'h0, 32'h2400_2F58, e);
    chk1("t1_wr_err", e, 1'b0);
    access(0, 1'b0, 32'h0, 32'h0, e);
    chk1("t1_rd_err", e, 1'b0);
    chk32("t1_ld_rdata", ld_rdata, 32'h2400_2F58);

    // 2: boot holds off if/dm
    set_port(1, 1'b1, 1'b0, 32'h0, '0);
    set_port(2, 1'b1, 1'b0, 32'h4, '0);
    nd = 0;
    nm = 0;
    repeat (10) begin
      @(negedge clk);
      if (if_done || dm_done) nd++;
      if (mem_read || mem_write) nm++;
    end
    chk32("t2_dones", 32'(nd), 32'd0);
    chk32("t2_mem_strobes", 32'(nm), 32'd0);
    set_port(1, 1'b0, 1'b0, '0, '0);
    set_port(2, 1'b0, 1'b0, '0, '0);
    boot = 1'b0;

    // 3: round robin from reset under continuous requests
    do_reset();
    start = cyc;
    set_port(1, 1'b1, 1'b0, 32'h0, '0);
    set_port(2, 1'b1, 1'b0, 32'h4, '0);
    for (int i = 0; i < 20 && seq.size() < 4; i++) begin
      @(negedge clk);
      if (if_done) begin seq.push_back(1); tms.push_back(cyc); end
      if (dm_done) begin seq.push_back(2); tms.push_back(cyc); end
    end
    set_port(1, 1'b0, 1'b0, '0, '0);
    set_port(2, 1'b0, 1'b0, '0, '0);
    chk32("t3_count", 32'(seq.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk32("t3_order", 32'(seq.size() > i ? seq[i] : 0), (i % 2 == 0) ? 32'd1 : 32'd2);
      if (i == 0) chk32("t3_first_lat", 32'(tms.size() > 0 ? tms[0] - start : -1), 32'd2);
      else chk32("t3_spacing", 32'(tms.size() > i ? tms[i] - tms[i-1] : -1), 32'd3);
    end
    @(negedge clk);

    // 4: errors leave memory and rdata alone
    access(2, 1'b1, 32'h10, 32'h1122_3344, e);
    access(2, 1'b0, 32'h10, 32'h0, e);
    chk32("t4_good_rdata", dm_rdata, 32'h1122_3344);
    mw0 = mw_count;
    access(2, 1'b1, 32'h404, 32'hDEAD_BEEF, e);
    chk1("t4_range_err", e, 1'b1);
    chk32("t4_no_write", 32'(mw_count - mw0), 32'd0);
    access(2, 1'b0, 32'h2, 32'h0, e);
    chk1("t4_misalign_err", e, 1'b1);
    chk32("t4_rdata_kept", dm_rdata, 32'h1122_3344);

    // 5: reset during the write access
    set_port(2, 1'b1, 1'b1, 32'h80, 32'hA5A5_A5A5);
    @(negedge clk);
    chk1("t5_write_active", mem_write, 1'b1);
    #2 reset = 1'b1;
    set_port(2, 1'b0, 1'b0, '0, '0);
    #1;
    chk1("t5_write_dropped", mem_write, 1'b0);
    chk32("t5_dm_rdata_clr", dm_rdata, 32'h0);
    chk32("t5_ld_rdata_clr", ld_rdata, 32'h0);
    #1 reset = 1'b0;
    @(negedge clk);
    access(2, 1'b0, 32'h80, 32'h0, e);
    chk32("t5_read_back", dm_rdata, 32'h0);

    // 6: boot rising mid-transaction
    access(2, 1'b1, 32'h2C, 32'hCAFE_0001, e);
    set_port(2, 1'b1, 1'b0, 32'h2C, '0);
    @(negedge clk);
    boot = 1'b1;
    set_port(1, 1'b1, 1'b0, 32'h2C, '0);
    @(negedge clk);
    chk1("t6_dm_done", dm_done, 1'b1);
    set_port(2, 1'b0, 1'b0, '0, '0);
    nd = 0;
    repeat (6) begin
      @(negedge clk);
      if (if_done) nd++;
    end
    chk32("t6_if_held", 32'(nd), 32'd0);
    boot  = 1'b0;
    start = cyc;
    lat   = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (if_done) begin
        lat = cyc - start;
        break;
      end
    end
    set_port(1, 1'b0, 1'b0, '0, '0);
    chk32("t6_if_lat", 32'(lat), 32'd2);
    @(negedge clk);
    chk32("t6_dm_rdata", dm_rdata, 32'hCAFE_0001);
    chk32("t6_if_rdata", if_rdata, 32'hCAFE_0001);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
